can_level_stuff: RTL and testbench
==================================

// Module: can_level_stuff
// PURPOSE
//  CAN bit-stuffing layer between can_level_bit (below) and the frame/packet controller (above).
//  Removes received stuff bits and inserts transmit stuff bits, so the upper layer sees only data bits.
//  Flags stuff-rule violations and TX/RX bit mismatches.
//  Purely bit-rate: acts only on bit_req pulses from can_level_bit.
// PARAMETERS
//  STUFF_LEN  3'd5  run length of equal bus bits after which a complement stuff bit follows (2..7)
// PORTS
//  clk        in   1  system clock
//  rstn       in   1  asynchronous active-low reset
//  bit_req    in   1  bit-border pulse from can_level_bit (req)
//  bit_rbit   in   1  sampled bus bit, valid with bit_req (rbit)
//  bit_tbit   out  1  next bus bit to drive, to can_level_bit tbit
//  stuff_en   in   1  1 = stuffing region (SOF..CRC); asserted by upper layer before SOF bit_req
//  tx_en      in   1  1 = this node is transmitting; enables bit_err check
//  abort      in   1  sync clear of stuffing state (error frame / bus-off)
//  up_req     out  1  data-bit pulse to upper layer; combinational = bit_req & ~stuff_pend
//  up_rbit    out  1  data bit, valid with up_req; combinational = bit_rbit
//  up_tbit    in   1  next data bit from upper layer; valid cycle after up_req, held until next bit_req
//  stuff_err  out  1  1-cycle pulse: received stuff bit not complement of the run
//  bit_err    out  1  1-cycle pulse: tx_en and sampled bit differs from bit driven for that slot
// BEHAVIOUR
//  Reset
//   - stuff_pend=0, stuff_val=1, last=1, run=0, tx_q=1
//   - outputs: stuff_err=0, bit_err=0; bit_tbit = up_tbit (pend=0)
//  Transmit mux
//   - bit_tbit = stuff_pend ? stuff_val : up_tbit (combinational)
//   - stuff_pend/stuff_val are registered at bit_req, so bit_tbit is valid the cycle after
//     bit_req, meeting can_level_bit's timing.
//   - tx_q captures bit_tbit on the cycle after bit_req (req_d) and holds it until the next req_d.
//  On each bit_req, in priority order:
//   1. abort=1: pend=0, run=0, last=1; no error pulses; up_req still follows the comb rule.
//   2. stuff_pend=1 (this slot is a stuff bit):
//      - up_req suppressed
//      - stuff_err<=(bit_rbit!=stuff_val)
//      - pend<=0, last<=bit_rbit, run<=1
//   3. Else, stuff_en=1:
//      - if bit_rbit==last: run<=run+1 (saturating at 7), else run<=1
//      - last<=bit_rbit
//      - if the new run==STUFF_LEN: pend<=1, stuff_val<=~bit_rbit, run<=0
//   4. Else (stuff_en=0): run<=0, last<=1; pend unchanged.
//      A pending stuff bit after the last CRC bit is still inserted and checked.
//  Bit error
//   - At every bit_req with tx_en=1 and abort=0: bit_err<=(bit_rbit!=tx_q).
//     Stuff slots are included.
//   - The upper layer masks arbitration/ACK slots.
//  Timing and width
//   - stuff_err/bit_err assert the cycle after bit_req for exactly 1 cycle.
//   - run is 3 bits wide; no other counters.
//  Boundaries
//   - bit_req while up_tbit unchanged: legal.
//   - stuff_en falling the same cycle as bit_req: the sampled value governs.
//   - Reset mid-frame returns to idle immediately; the first bit_req after reset is treated as data.
// TESTING
//  T1 RX: stuff_en=1, bus bits 0,0,0,0,0,1,1 -> up_req on bits 1-5 and 7 only; 6th slot swallowed;
//     stuff_err=0.
//  T2 RX violation: bits 1,1,1,1,1,1 with stuff_en=1 -> 6th slot: stuff_err=1 for 1 cycle, no up_req.
//  T3 TX: up_tbit=0 for 5 data bits, loopback rbit=bit_tbit -> 6th slot bit_tbit=1;
//     upper sees 5 up_req then continues; bit_err=0.
//  T4 bit error: tx_en=1, drive 1, force bit_rbit=0 -> bit_err pulse next cycle; no stuff_err.
//  T5 region edges: stuff_en=0 with 8 equal bits -> no stuffing;
//     drop stuff_en right after 5th equal bit -> stuff bit still inserted.
//  T6 abort/reset: abort (or rstn low) with stuff_pend=1 -> next slot is data, up_req=1,
//     bit_tbit=up_tbit.

Source files
------------

// File: rtl/can_level_stuff.sv
// CAN bit-stuffing layer: strips received stuff bits, inserts transmit stuff bits,
// and reports stuff-rule violations and transmit/receive bit mismatches.
module can_level_stuff #(
  parameter logic [2:0] STUFF_LEN = 3'd5
) (
  input  logic clk,
  input  logic rstn,
  input  logic bit_req,
  input  logic bit_rbit,
  output logic bit_tbit,
  input  logic stuff_en,
  input  logic tx_en,
  input  logic abort,
  output logic up_req,
  output logic up_rbit,
  input  logic up_tbit,
  output logic stuff_err,
  output logic bit_err
);

  // Handshake: bit_req is a 1-cycle pulse with bit_rbit valid in that cycle; up_req mirrors it
  // for data slots only, and up_tbit must be stable from the cycle after up_req until the next bit_req.
  logic       stuff_pend;
  logic       stuff_val;
  logic       last;
  logic       tx_q;
  logic       req_d;
  logic [2:0] run;
  logic [2:0] run_inc;
  logic [2:0] run_nxt;

  assign bit_tbit = stuff_pend ? stuff_val : up_tbit;
  assign up_req   = bit_req & ~stuff_pend;
  assign up_rbit  = bit_rbit;

  always_comb begin
    run_inc = (run == 3'd7) ? run : run + 3'd1;
    run_nxt = (bit_rbit == last) ? run_inc : 3'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stuff_pend <= 1'b0;
      stuff_val  <= 1'b1;
      last       <= 1'b1;
      run        <= 3'd0;
      tx_q       <= 1'b1;
      req_d      <= 1'b0;
      stuff_err  <= 1'b0;
      bit_err    <= 1'b0;
    end else begin
      stuff_err <= 1'b0;
      bit_err   <= 1'b0;
      req_d     <= bit_req;
      // tx_q holds the bit actually driven for the slot that the next bit_req samples
      if (req_d) tx_q <= bit_tbit;
      if (bit_req) begin
        if (tx_en && !abort) bit_err <= (bit_rbit != tx_q);
        if (abort) begin
          stuff_pend <= 1'b0;
          run        <= 3'd0;
          last       <= 1'b1;
        end else if (stuff_pend) begin
          stuff_err  <= (bit_rbit != stuff_val);
          stuff_pend <= 1'b0;
          last       <= bit_rbit;
          run        <= 3'd1;
        end else if (stuff_en) begin
          last <= bit_rbit;
          if (run_nxt == STUFF_LEN) begin
            stuff_pend <= 1'b1;
            stuff_val  <= ~bit_rbit;
            run        <= 3'd0;
          end else begin
            run <= run_nxt;
          end
        end else begin
          run  <= 3'd0;
          last <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_can_level_stuff.sv
// Self-checking bench for can_level_stuff: directed scenarios plus randomized bit streams
// checked against a bit-history model of the stuffing rules.
module tb_can_level_stuff;

  localparam int STUFF_LEN = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic bit_req = 1'b0;
  logic bit_rbit = 1'b1;
  logic bit_tbit;
  logic stuff_en = 1'b0;
  logic tx_en = 1'b0;
  logic abort = 1'b0;
  logic up_req;
  logic up_rbit;
  logic up_tbit = 1'b1;
  logic stuff_err;
  logic bit_err;

  int errors = 0;
  int checks = 0;

  can_level_stuff #(.STUFF_LEN(3'd5)) dut (
    .clk(clk), .rstn(rstn), .bit_req(bit_req), .bit_rbit(bit_rbit), .bit_tbit(bit_tbit),
    .stuff_en(stuff_en), .tx_en(tx_en), .abort(abort), .up_req(up_req), .up_rbit(up_rbit),
    .up_tbit(up_tbit), .stuff_err(stuff_err), .bit_err(bit_err)
  );

  always #5 clk = ~clk;

  // Model: bus bits seen since the region (re)started or the last stuff decision
  bit hist[$];
  bit m_pend, m_sval, m_tx;

  bit obs_up, obs_urb, obs_serr, obs_berr, obs_tbit, obs_pulse;
  bit exp_up, exp_urb, exp_serr, exp_berr, exp_tbit;

  task automatic model_reset();
    hist.delete();
    m_pend = 1'b0;
    m_sval = 1'b1;
    m_tx   = 1'b1;
  endtask

  task automatic dut_reset();
    bit_req = 1'b0;
    abort   = 1'b0;
    rstn    = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic run_slot(input bit r, input bit en, input bit tx, input bit ab, input bit u);
    int c;
    @(negedge clk);
    bit_req = 1'b1; bit_rbit = r; stuff_en = en; tx_en = tx; abort = ab;
    #1;
    obs_up  = up_req;
    obs_urb = up_rbit;
    exp_up   = !m_pend;
    exp_urb  = r;
    exp_berr = tx && !ab && (r != m_tx);
    exp_serr = 1'b0;
    if (ab) begin
      m_pend = 1'b0;
      hist.delete();
    end else if (m_pend) begin
      exp_serr = (r != m_sval);
      m_pend = 1'b0;
      hist.delete();
      hist.push_back(r);
    end else if (en) begin
      hist.push_back(r);
      c = 0;
      for (int k = hist.size() - 1; k >= 0; k--) begin
        if (hist[k] != r) break;
        c++;
      end
      if (c == STUFF_LEN) begin
        m_pend = 1'b1;
        m_sval = !r;
        hist.delete();
      end
    end else begin
      hist.delete();
    end
    @(negedge clk);
    bit_req = 1'b0; abort = 1'b0; up_tbit = u;
    #1;
    obs_serr = stuff_err;
    obs_berr = bit_err;
    obs_tbit = bit_tbit;
    exp_tbit = m_pend ? m_sval : u;
    m_tx = exp_tbit;
    @(negedge clk);
    #1;
    obs_pulse = stuff_err | bit_err;
  endtask

  task automatic test_reset();
    rstn = 1'b0; bit_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up_tbit = i[0];
      #3;
      if (stuff_err !== 1'b0) begin errors++; $display("FAIL reset stuff_err: got %b exp 0", stuff_err); end
      if (bit_err !== 1'b0) begin errors++; $display("FAIL reset bit_err: got %b exp 0", bit_err); end
      if (bit_tbit !== up_tbit) begin errors++; $display("FAIL reset bit_tbit: got %b exp %b", bit_tbit, up_tbit); end
      if (up_req !== 1'b0) begin errors++; $display("FAIL reset up_req: got %b exp 0", up_req); end
      checks += 4;
    end
    dut_reset();
  endtask

  task automatic test_rx_destuff();
    bit t1[7] = '{0, 0, 0, 0, 0, 1, 1};
    int ups;
    dut_reset();
    ups = 0;
    for (int i = 0; i < 7; i++) begin
      run_slot(t1[i], 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      ups += int'(obs_up);
      if (obs_up !== exp_up) begin errors++; $display("FAIL rx up_req slot %0d: got %b exp %b", i, obs_up, exp_up); end
      if (obs_urb !== exp_urb) begin errors++; $display("FAIL rx up_rbit slot %0d: got %b exp %b", i, obs_urb, exp_urb); end
      if (obs_serr !== 1'b0) begin errors++; $display("FAIL rx stuff_err slot %0d: got %b exp 0", i, obs_serr); end
      if (obs_tbit !== exp_tbit) begin errors++; $display("FAIL rx bit_tbit slot %0d: got %b exp %b", i, obs_tbit, exp_tbit); end
      checks += 4;
    end
    if (ups !== 6) begin errors++; $display("FAIL rx up_req count: got %0d exp 6", ups); end
    checks++;
    dut_reset();
    for (int i = 0; i < 6; i++) begin
      run_slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (obs_up !== (i != 5)) begin errors++; $display("FAIL viol up_req slot %0d: got %b exp %b", i, obs_up, i != 5); end
      if (obs_serr !== (i == 5)) begin errors++; $display("FAIL viol stuff_err slot %0d: got %b exp %b", i, obs_serr, i == 5); end
      if (obs_pulse !== 1'b0) begin errors++; $display("FAIL viol pulse width slot %0d: got %b exp 0", i, obs_pulse); end
      checks += 3;
    end
  endtask

  task automatic test_tx_stuff();
    dut_reset();
    up_tbit = 1'b0;
    run_slot(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_slot(m_tx, 1'b1, 1'b1, 1'b0, 1'b0);
      if (obs_tbit !== exp_tbit) begin errors++; $display("FAIL tx bit_tbit slot %0d: got %b exp %b", i, obs_tbit, exp_tbit); end
      if (obs_up !== exp_up) begin errors++; $display("FAIL tx up_req slot %0d: got %b exp %b", i, obs_up, exp_up); end
      if (obs_berr !== 1'b0) begin errors++; $display("FAIL tx bit_err slot %0d: got %b exp 0", i, obs_berr); end
      if (obs_serr !== 1'b0) begin errors++; $display("FAIL tx stuff_err slot %0d: got %b exp 0", i, obs_serr); end
      checks += 4;
      if (i == 4) begin
        if (obs_tbit !== 1'b1) begin errors++; $display("FAIL tx stuff bit after 5 zeros: got %b exp 1", obs_tbit); end
        checks++;
      end
    end
  endtask

  task automatic test_bit_err();
    dut_reset();
    run_slot(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    run_slot(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    if (obs_berr !== 1'b1) begin errors++; $display("FAIL biterr bit_err: got %b exp 1", obs_berr); end
    if (obs_serr !== 1'b0) begin errors++; $display("FAIL biterr stuff_err: got %b exp 0", obs_serr); end
    if (obs_pulse !== 1'b0) begin errors++; $display("FAIL biterr pulse width: got %b exp 0", obs_pulse); end
    run_slot(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    if (obs_berr !== 1'b0) begin errors++; $display("FAIL biterr masked by abort: got %b exp 0", obs_berr); end
    checks += 4;
  endtask

  task automatic test_region_edges();
    dut_reset();
    for (int i = 0; i < 8; i++) begin
      run_slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (obs_up !== 1'b1) begin errors++; $display("FAIL edge no-stuff up_req slot %0d: got %b exp 1", i, obs_up); end
      checks++;
    end
    for (int i = 0; i < 5; i++) run_slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (obs_tbit !== 1'b1) begin errors++; $display("FAIL edge pending stuff tbit: got %b exp 1", obs_tbit); end
    run_slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (obs_up !== 1'b0) begin errors++; $display("FAIL edge late stuff up_req: got %b exp 0", obs_up); end
    if (obs_serr !== 1'b1) begin errors++; $display("FAIL edge late stuff stuff_err: got %b exp 1", obs_serr); end
    run_slot(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (obs_up !== 1'b1) begin errors++; $display("FAIL edge after stuff up_req: got %b exp 1", obs_up); end
    checks += 4;
  endtask

  task automatic test_abort_reset();
    dut_reset();
    for (int i = 0; i < 5; i++) run_slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_slot(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run_slot(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    if (obs_up !== 1'b1) begin errors++; $display("FAIL abort next up_req: got %b exp 1", obs_up); end
    if (obs_tbit !== 1'b1) begin errors++; $display("FAIL abort next bit_tbit: got %b exp 1", obs_tbit); end
    if (obs_serr !== 1'b0) begin errors++; $display("FAIL abort next stuff_err: got %b exp 0", obs_serr); end
    dut_reset();
    for (int i = 0; i < 5; i++) run_slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dut_reset();
    up_tbit = 1'b0;
    #1;
    if (bit_tbit !== 1'b0) begin errors++; $display("FAIL reset-midframe bit_tbit: got %b exp 0", bit_tbit); end
    run_slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (obs_up !== 1'b1) begin errors++; $display("FAIL reset-midframe up_req: got %b exp 1", obs_up); end
    checks += 5;
  endtask

  task automatic test_random();
    bit prev, r, en, tx, ab;
    dut_reset();
    prev = 1'b1;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      tx = ($urandom_range(0, 1) == 1);
      ab = ($urandom_range(0, 39) == 0);
      if (tx && $urandom_range(0, 9) != 0) r = m_tx;
      else r = ($urandom_range(0, 3) == 0) ? !prev : prev;
      prev = r;
      run_slot(r, en, tx, ab, 1'($urandom_range(0, 1)));
      if (obs_up !== exp_up) begin errors++; $display("FAIL rand up_req slot %0d: got %b exp %b", i, obs_up, exp_up); end
      if (obs_urb !== exp_urb) begin errors++; $display("FAIL rand up_rbit slot %0d: got %b exp %b", i, obs_urb, exp_urb); end
      if (obs_serr !== exp_serr) begin errors++; $display("FAIL rand stuff_err slot %0d: got %b exp %b", i, obs_serr, exp_serr); end
      if (obs_berr !== exp_berr) begin errors++; $display("FAIL rand bit_err slot %0d: got %b exp %b", i, obs_berr, exp_berr); end
      if (obs_tbit !== exp_tbit) begin errors++; $display("FAIL rand bit_tbit slot %0d: got %b exp %b", i, obs_tbit, exp_tbit); end
      if (obs_pulse !== 1'b0) begin errors++; $display("FAIL rand pulse width slot %0d: got %b exp 0", i, obs_pulse); end
      checks += 6;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rx_destuff();
    test_tx_stuff();
    test_bit_err();
    test_region_edges();
    test_abort_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
